// File: rtl/coin_collector.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | coin_collector : coin acceptor and credit accumulator for the vending FSM |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module coin_collector #(
  parameter int PRICE   = 10,
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin_value,
  input  logic       cancel,
  input  logic       consume,
  output logic [3:0] coin_in,
  output logic       ready,
  output logic [4:0] credit,
  output logic       reject,
  output logic       change_valid,
  output logic [4:0] change_out
);

  localparam logic [4:0] C_PRICE      = 5'(PRICE);
  localparam logic [3:0] C_COIN_PRICE = 4'(PRICE);
  localparam logic [7:0] C_TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_READY   = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_credit, w_credit_nxt;
  logic [7:0] r_idle_cnt, w_idle_cnt_nxt;
  logic       r_reject, w_reject_nxt;
  logic       r_chg_valid, w_chg_valid_nxt;
  logic [4:0] r_chg_out, w_chg_out_nxt;
  logic       r_ready;
  logic [3:0] r_coin_in;

  logic       w_legal;
  logic [4:0] w_sum;
  logic [4:0] w_over;

  assign w_legal = coin_valid &&
                   (coin_value == 4'd1 || coin_value == 4'd2 ||
                    coin_value == 4'd5 || coin_value == 4'd10);
  // credit is always zero in IDLE, so one adder serves both accepting states
  assign w_sum   = r_credit + {1'b0, coin_value};
  assign w_over  = w_sum - C_PRICE;

  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_idle_cnt_nxt  = r_idle_cnt;
    w_reject_nxt    = 1'b0;
    w_chg_valid_nxt = 1'b0;
    w_chg_out_nxt   = 5'd0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (r_state == S_COLLECT && cancel) begin
          w_state_nxt     = S_REFUND;
          w_reject_nxt    = coin_valid;
          w_chg_valid_nxt = 1'b1;
          w_chg_out_nxt   = r_credit;
        end else if (w_legal) begin
          w_idle_cnt_nxt = 8'd0;
          if (w_sum >= C_PRICE) begin
            w_state_nxt     = S_READY;
            w_credit_nxt    = C_PRICE;
            w_chg_valid_nxt = (w_over != 5'd0);
            w_chg_out_nxt   = w_over;
          end else begin
            w_state_nxt  = S_COLLECT;
            w_credit_nxt = w_sum;
          end
        end else begin
          w_reject_nxt = coin_valid;
          if (r_state == S_COLLECT) begin
            if (r_idle_cnt == C_TMO_LAST) begin
              w_state_nxt     = S_REFUND;
              w_chg_valid_nxt = 1'b1;
              w_chg_out_nxt   = r_credit;
            end else begin
              w_idle_cnt_nxt = r_idle_cnt + 8'd1;
            end
          end
        end
      end
      S_READY: begin
        w_reject_nxt = coin_valid;
        if (consume) begin
          w_state_nxt  = S_IDLE;
          w_credit_nxt = 5'd0;
        end
      end
      default: begin
        w_reject_nxt   = coin_valid;
        w_state_nxt    = S_IDLE;
        w_credit_nxt   = 5'd0;
        w_idle_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_credit    <= 5'd0;
      r_idle_cnt  <= 8'd0;
      r_reject    <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_out   <= 5'd0;
      r_ready     <= 1'b0;
      r_coin_in   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_credit    <= w_credit_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_reject    <= w_reject_nxt;
      r_chg_valid <= w_chg_valid_nxt;
      r_chg_out   <= w_chg_out_nxt;
      r_ready     <= (w_state_nxt == S_READY);
      r_coin_in   <= (w_state_nxt == S_READY) ? C_COIN_PRICE : 4'd0;
    end
  end

  assign coin_in      = r_coin_in;
  assign ready        = r_ready;
  assign credit       = r_credit;
  assign reject       = r_reject;
  assign change_valid = r_chg_valid;
  assign change_out   = r_chg_out;

endmodule
`default_nettype wire

// File: doc/coin_collector.md
# coin_collector

Upstream stage of the vending machine. Accepts individual coin insertions, accumulates credit against a fixed price, and presents a clean `coin_in` value to the vending FSM once the price is reached. Rejects invalid denominations, returns overpayment as change, and refunds on cancel or inactivity timeout.

## Interface
Parameters:
- `PRICE`, default 10: credit required; the value driven on `coin_in` when ready (≤15).
- `TIMEOUT`, default 20: idle cycles in COLLECT before an automatic refund (≥1, ≤255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coin_valid`  in  1  one-cycle strobe; a coin is present on `coin_value`.
- `coin_value`  in  4  denomination; only 1, 2, 5 and 10 are legal.
- `cancel`  in  1  user cancel; level, sampled each cycle.
- `consume`  in  1  one-cycle strobe from the vending stage; credit has been used.
- `coin_in`  out  4  equals `PRICE` while `ready`=1, else 0.
- `ready`  out  1  credit ≥ `PRICE` has been latched and is awaiting `consume`.
- `credit`  out  5  current accumulated credit.
- `reject`  out  1  one-cycle pulse; the coin just strobed was returned.
- `change_valid`  out  1  one-cycle pulse; `change_out` is valid.
- `change_out`  out  5  amount returned; 0 when `change_valid`=0.

## Operation
- States: IDLE, COLLECT, READY, REFUND.
- Legal coin: `coin_valid`=1 and `coin_value` ∈ {1,2,5,10}. Any other value with `coin_valid`=1 produces `reject`=1 and leaves credit unchanged.
- IDLE: `credit`=0. A legal coin sets credit to its value. If the value ≥ `PRICE`, go to READY; otherwise go to COLLECT.
- COLLECT: a legal coin adds to credit using 5-bit arithmetic (maximum 9+10=19, so no overflow).
  - If the new sum ≥ `PRICE`, go to READY. In the same cycle, fire `change_valid` with `change_out` = sum − `PRICE`, but only if that value is nonzero.
  - `credit` then holds `PRICE`.
- COLLECT timeout: the idle counter resets on every legal coin. When it reaches `TIMEOUT`, go to REFUND.
- Cancel in COLLECT goes to REFUND. Cancel takes priority over a coin arriving in the same cycle; that coin is rejected.
- REFUND is a single cycle: `change_valid`=1, `change_out`=credit. Credit clears, then the block returns to IDLE.
- READY: `ready`=1 and `coin_in`=`PRICE`.
  - Any coin arriving in READY is rejected.
  - `cancel` is ignored.
  - `consume`=1 clears credit and returns to IDLE.
- `consume` is ignored outside READY.
- Cancel in IDLE has no effect.

## Timing
- All outputs are registered and update on the rising edge after the input is sampled.
- Reset values: state=IDLE, `credit`=0, `coin_in`=0, `ready`=0, `reject`=0, `change_valid`=0, `change_out`=0, idle counter=0.
- Reset is checked first and overrides every other input in the same cycle. Reset mid-operation discards credit without issuing a refund pulse.
- Latency from coin strobe to updated `credit` or `ready`: 1 cycle.
- Overpayment change and the rise of `ready` occur on the same edge.
- Latency from `consume` to `ready`=0: 1 cycle. The vending stage sees `coin_in`=0 from that edge onward.
- A new coin is accepted no earlier than the cycle after the block returns to IDLE.
- Timeout: with the last legal coin strobed at cycle t, REFUND is entered on edge t+1+`TIMEOUT`, and `change_valid` is high in that cycle.
- `reject` pulses on the edge after the offending strobe.
- `change_valid` is never high for more than one consecutive cycle per event.

## Test plan
- Reset then 5, 5 (one cycle apart): `credit` 5 then 10 with `ready`=1, `coin_in`=10, no change. Then `consume` pulse: next cycle `ready`=0, `coin_in`=0, `credit`=0.
- 5 then 10: `ready`=1 and `change_valid`=1 with `change_out`=5 on the same edge; `credit`=10.
- `coin_value`=3, then 7: two `reject` pulses, `credit` stays 0, state stays IDLE.
- 2 then 1, then wait `TIMEOUT`=20 cycles: REFUND with `change_out`=3, then IDLE and `credit`=0. A variant with a coin at cycle 19 restarts the count.
- 5 then `cancel` together with a coin 2 in the same cycle: `reject`=1 and `change_out`=5 refund, no 7.
- In READY, strobe coin 5 and assert `cancel`: `reject`=1, `ready` still 1. Assert `rst` in READY: all outputs 0 the next cycle, with no `change_valid`.
